// File: rtl/nibble_assembler_pkg.sv
// nibble_assembler_pkg: shared FSM state type and nibble/index widths.
package nibble_assembler_pkg;
    typedef enum logic {FILL, FULL} state_t;
    localparam int NIB_W = 4;
    localparam int IDX_W = 3;
endpackage

// File: rtl/nibble_assembler_if.sv
// nibble_assembler_if: nibble input, word output and status handshake bundle.
interface nibble_assembler_if import nibble_assembler_pkg::*; #(parameter int NIBBLES = 8);
    logic [NIB_W-1:0]         nib;
    logic                     nib_valid;
    logic                     nib_ready;
    logic                     clear;
    logic [NIB_W*NIBBLES-1:0] word;
    logic                     word_valid;
    logic                     word_ready;
    logic [IDX_W-1:0]         idx;
    logic                     ovf;
    modport master (output nib, nib_valid, clear, word_ready,
                    input  nib_ready, word, word_valid, idx, ovf);
    modport slave  (input  nib, nib_valid, clear, word_ready,
                    output nib_ready, word, word_valid, idx, ovf);
endinterface

// File: rtl/nibble_assembler_demux.sv
// nib_demux_1to8: one-hot nibble slot write enable from idx and accept strobe.
module nib_demux_1to8 import nibble_assembler_pkg::*; (
    input  logic [IDX_W-1:0] idx,
    input  logic             acc,
    output logic [7:0]       we
);
    assign we = acc ? 8'd1 << idx : 8'd0;
endmodule

// File: rtl/nibble_assembler.sv
// nibble_assembler: packs NIBBLES accepted nibbles (LSB first) into one word.
module nibble_assembler import nibble_assembler_pkg::*; #(
    parameter int NIBBLES = 8
) (
    input logic clk,
    input logic reset,
    nibble_assembler_if.slave bus
);
    state_t                   state, state_n;
    logic                     acc, last;
    logic [7:0]               we;
    logic [IDX_W-1:0]         idx;
    logic [NIB_W*NIBBLES-1:0] word;
    logic                     ovf;
    assign acc            = bus.nib_valid && state == FILL;
    assign last           = idx == IDX_W'(NIBBLES - 1);
    assign bus.nib_ready  = state == FILL;
    assign bus.word_valid = state == FULL;
    assign bus.word       = word;
    assign bus.idx        = idx;
    assign bus.ovf        = ovf;
    nib_demux_1to8 u_demux (.idx(idx), .acc(acc), .we(we));
    always_comb begin
        state_n = state;
        state_n = bus.clear ? FILL :
                  state == FULL ? (bus.word_ready ? FILL : FULL) :
                  (acc && last ? FULL : FILL);
    end
    always_ff @(posedge clk) begin
        if (reset) state <= FILL;
        else       state <= state_n;
    end
    // Nibble writes only happen in FILL, so they never collide with the FULL drain clear.
    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            idx  <= '0;
            word <= '0;
            ovf  <= 1'b0;
        end else begin
            ovf <= ovf | (state == FULL && bus.nib_valid);
            if (state == FULL && bus.word_ready) word <= '0;
            for (int i = 0; i < NIBBLES; i++)
                if (we[i]) word[NIB_W*i +: NIB_W] <= bus.nib;
            if (acc) idx <= last ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_nibble_assembler.sv
// tb_nibble_assembler: directed checks of fill, drain, overflow, clear and reset.
module tb_nibble_assembler;
    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;
    nibble_assembler_if #(.NIBBLES(8)) a();
    nibble_assembler_if #(.NIBBLES(2)) b();
    nibble_assembler #(.NIBBLES(8)) u_a (.clk(clk), .reset(reset), .bus(a));
    nibble_assembler #(.NIBBLES(2)) u_b (.clk(clk), .reset(reset), .bus(b));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask
    task automatic send(input logic [3:0] n);
        a.nib = n;
        a.nib_valid = 1'b1;
        tick();
        a.nib_valid = 1'b0;
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_word"}, a.word, 32'h0);
        chk({tag, "_wvalid"}, 32'(a.word_valid), 32'd0);
        chk({tag, "_nready"}, 32'(a.nib_ready), 32'd1);
        chk({tag, "_idx"}, 32'(a.idx), 32'd0);
        chk({tag, "_ovf"}, 32'(a.ovf), 32'd0);
    endtask
    initial begin
        logic [3:0]  n4;
        logic [31:0] seen [2];
        int          nvalid, n;
        reset = 1'b1;
        {a.nib, a.nib_valid, a.clear, a.word_ready} = '0;
        {b.nib, b.nib_valid, b.clear, b.word_ready} = '0;
        tick();
        tick();
        reset = 1'b0;
        chk_reset("rst");
        // fill 1..8
        for (int k = 1; k <= 8; k++) begin
            n4 = 4'(k);
            send(n4);
            chk("fill_idx", 32'(a.idx), 32'(k % 8));
        end
        chk("full_word", a.word, 32'h87654321);
        chk("full_wvalid", 32'(a.word_valid), 32'd1);
        chk("full_nready", 32'(a.nib_ready), 32'd0);
        // hold FULL while offering
        a.nib = 4'hF;
        a.nib_valid = 1'b1;
        repeat (5) tick();
        chk("hold_word", a.word, 32'h87654321);
        chk("hold_wvalid", 32'(a.word_valid), 32'd1);
        chk("hold_ovf", 32'(a.ovf), 32'd1);
        a.nib_valid = 1'b0;
        a.word_ready = 1'b1;
        tick();
        a.word_ready = 1'b0;
        chk("drain_wvalid", 32'(a.word_valid), 32'd0);
        chk("drain_word", a.word, 32'h0);
        chk("drain_idx", 32'(a.idx), 32'd0);
        chk("drain_ovf_sticky", 32'(a.ovf), 32'd1);
        // partial fill then clear with a competing nibble
        send(4'hA);
        send(4'hB);
        send(4'hC);
        chk("part_idx", 32'(a.idx), 32'd3);
        chk("part_word", a.word, 32'h00000CBA);
        a.clear = 1'b1;
        a.nib = 4'hD;
        a.nib_valid = 1'b1;
        tick();
        a.clear = 1'b0;
        a.nib_valid = 1'b0;
        chk("clr_word", a.word, 32'h0);
        chk("clr_idx", 32'(a.idx), 32'd0);
        chk("clr_ovf", 32'(a.ovf), 32'd0);
        tick();
        chk("clr_noD", a.word, 32'h0);
        // streaming with word_ready tied high; producer holds nib until accepted
        a.word_ready = 1'b1;
        nvalid = 0;
        n = 0;
        for (int c = 0; c < 24; c++) begin
            a.nib = 4'(n);
            a.nib_valid = n < 16;
            if (a.word_valid) begin
                if (nvalid < 2) seen[nvalid] = a.word;
                nvalid++;
            end
            if (a.nib_ready && n < 16) n++;
            tick();
        end
        a.nib_valid = 1'b0;
        a.word_ready = 1'b0;
        chk("strm_accepted", 32'(n), 32'd16);
        chk("strm_nvalid", 32'(nvalid), 32'd2);
        chk("strm_word0", seen[0], 32'h76543210);
        chk("strm_word1", seen[1], 32'hFEDCBA98);
        chk("strm_ovf", 32'(a.ovf), 32'd1);
        chk("strm_idle_word", a.word, 32'h0);
        // reset while FULL with live handshakes
        for (int k = 0; k < 8; k++) send(4'h9);
        chk("r1_pre_wvalid", 32'(a.word_valid), 32'd1);
        reset = 1'b1;
        a.nib_valid = 1'b1;
        a.word_ready = 1'b1;
        tick();
        reset = 1'b0;
        a.nib_valid = 1'b0;
        a.word_ready = 1'b0;
        chk_reset("r1");
        // reset after 5 accepts
        for (int k = 1; k <= 5; k++) begin
            n4 = 4'(k);
            send(n4);
        end
        chk("r2_pre_word", a.word, 32'h00054321);
        chk("r2_pre_idx", 32'(a.idx), 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset("r2");
        send(4'h7);
        chk("r2_next_word", a.word, 32'h7);
        chk("r2_next_idx", 32'(a.idx), 32'd1);
        // NIBBLES=2 instance
        chk("b_rst_word", 32'(b.word), 32'h0);
        b.nib = 4'h5;
        b.nib_valid = 1'b1;
        tick();
        chk("b_mid_word", 32'(b.word), 32'h05);
        chk("b_mid_idx", 32'(b.idx), 32'd1);
        b.nib = 4'hA;
        tick();
        b.nib_valid = 1'b0;
        chk("b_word", 32'(b.word), 32'hA5);
        chk("b_wvalid", 32'(b.word_valid), 32'd1);
        chk("b_idx", 32'(b.idx), 32'd0);
        chk("b_nready", 32'(b.nib_ready), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
